mem_arbiter: RTL and testbench

- Sequences the single-port 32x64 main memory (mem_read/mem_write, registered 1-cycle read) and shares it between two requesters: instruction fetch (port F, read-only) and load/store unit (port D, read/write).
- Sits between the core's fetch and LS stages and the main memory.
- Uses a req/ack handshake per port, priority arbitration with a starvation guard, and range checking.

---
 rtl/mem_ctrl_pkg.sv | 20 ++
 rtl/mem_arb_pick.sv | 58 +++++
 rtl/mem_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the main-memory arbiter.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic       PORT_F    = 1'b0;
    localparam logic       PORT_D    = 1'b1;
    localparam int         MEM_DEPTH = 32;
    localparam logic [2:0] SUP_DWORD = 3'b011;

    // Full-width range check: any set upper bit lands out of range.
    function automatic logic addr_oob(input logic [63:0] addr, input int depth);
        return (addr >= 64'(depth));
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Fixed D-over-F priority with a streak counter that forces F after MAX_STREAK D wins.
module mem_arb_pick #(
    parameter int MAX_STREAK = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic f_req,
    input  logic d_req,
    input  logic grant_en,
    output logic grant_f,
    output logic grant_d
);

    localparam int SW = $clog2(MAX_STREAK + 1);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;
    logic          force_f_s;

    assign force_f_s = f_req && (streak_q == SW'(MAX_STREAK));

    // Winner selection, only while the FSM is idle.
    always_comb begin
        grant_f = 1'b0;
        grant_d = 1'b0;
        if (grant_en) begin
            grant_d = d_req && !force_f_s;
            grant_f = f_req && !grant_d;
        end else begin
            grant_f = 1'b0;
            grant_d = 1'b0;
        end
    end

    // Streak update: clear on F grant or absent F, saturating count of D wins over a waiting F.
    always_comb begin
        streak_d = streak_q;
        if (!grant_en) begin
            streak_d = streak_q;
        end else if (grant_f || !f_req) begin
            streak_d = '0;
        end else if (grant_d && (streak_q != SW'(MAX_STREAK))) begin
            streak_d = streak_q + SW'(1);
        end else begin
            streak_d = streak_q;
        end
    end

    // Streak register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) sequencer for the single-port main memory.
// Optional grant/stall counters are enabled by defining MEM_ARB_PERF_CNT_EN.
module mem_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH      = MEM_DEPTH,
    parameter int MAX_STREAK = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_req,
    input  logic [63:0] f_addr,
    output logic        f_ack,
    output logic [63:0] f_rdata,
    output logic        f_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_sup,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_ack,
    output logic [63:0] d_rdata,
    output logic        d_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_sup,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0] f_grant_cnt,
    output logic [31:0] d_grant_cnt,
    output logic [31:0] stall_cnt
`endif
);

    state_e      state_q, state_d;
    logic        win_q, win_d, we_q, we_d, err_q, err_d;
    logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [2:0]  mem_sup_q, mem_sup_d;
    logic [63:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic        f_ack_q, f_ack_d, d_ack_q, d_ack_d;
    logic        f_err_q, f_err_d, d_err_q, d_err_d;
    logic        grant_f_s, grant_d_s, grant_en_s;
    logic [63:0] sel_addr_s;
    logic        sel_we_s, oob_s;

    assign grant_en_s = (state_q == IDLE);
    assign sel_addr_s = grant_d_s ? d_addr : f_addr;
    assign sel_we_s   = grant_d_s & d_we;
    assign oob_s      = addr_oob(sel_addr_s, DEPTH);

    mem_arb_pick #(
        .MAX_STREAK (MAX_STREAK)
    ) u_pick (
        .clk      (clk),
        .rst_n    (rst_n),
        .f_req    (f_req),
        .d_req    (d_req),
        .grant_en (grant_en_s),
        .grant_f  (grant_f_s),
        .grant_d  (grant_d_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; out-of-range requests skip the memory cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_f_s || grant_d_s) begin
                    state_d = oob_s ? RESP : ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next-values: latch the winner in IDLE, pulse ack/err on entry to RESP.
    always_comb begin
        win_d       = win_q;
        we_d        = we_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_sup_d   = mem_sup_q;
        mem_wdata_d = mem_wdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_f_s || grant_d_s) begin
                    win_d       = grant_d_s ? PORT_D : PORT_F;
                    we_d        = sel_we_s;
                    err_d       = oob_s;
                    mem_addr_d  = sel_addr_s;
                    mem_sup_d   = grant_d_s ? d_sup : SUP_DWORD;
                    mem_wdata_d = grant_d_s ? d_wdata : 64'h0;
                    mem_read_d  = !oob_s && !sel_we_s;
                    mem_write_d = !oob_s && sel_we_s;
                end else begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            ACCESS:  mem_read_d = 1'b0;
            RESP:    mem_read_d = 1'b0;
            default: mem_read_d = 1'b0;
        endcase
        f_ack_d = (state_d == RESP) && (win_d == PORT_F);
        d_ack_d = (state_d == RESP) && (win_d == PORT_D);
        f_err_d = f_ack_d && err_d;
        d_err_d = d_ack_d && err_d;
    end

    // Output and latched-transaction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q       <= PORT_F;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_sup_q   <= 3'b000;
            mem_addr_q  <= 64'h0;
            mem_wdata_q <= 64'h0;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            f_err_q     <= 1'b0;
            d_err_q     <= 1'b0;
        end else begin
            win_q       <= win_d;
            we_q        <= we_d;
            err_q       <= err_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_sup_q   <= mem_sup_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            f_ack_q     <= f_ack_d;
            d_ack_q     <= d_ack_d;
            f_err_q     <= f_err_d;
            d_err_q     <= d_err_d;
        end
    end

    // Memory read data arrives in RESP, so it is steered straight through to the winner.
    always_comb begin
        f_rdata = 64'h0;
        d_rdata = 64'h0;
        if (f_ack_q && !we_q && !err_q) begin
            f_rdata = mem_rdata;
        end else begin
            f_rdata = 64'h0;
        end
        if (d_ack_q && !we_q && !err_q) begin
            d_rdata = mem_rdata;
        end else begin
            d_rdata = 64'h0;
        end
    end

    assign f_ack     = f_ack_q;
    assign d_ack     = d_ack_q;
    assign f_err     = f_err_q;
    assign d_err     = d_err_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_sup   = mem_sup_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] f_grant_cnt_q, d_grant_cnt_q, stall_cnt_q;

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_grant_cnt_q <= 32'h0;
            d_grant_cnt_q <= 32'h0;
            stall_cnt_q   <= 32'h0;
        end else begin
            if (grant_f_s) f_grant_cnt_q <= f_grant_cnt_q + 32'd1;
            if (grant_d_s) d_grant_cnt_q <= d_grant_cnt_q + 32'd1;
            if ((f_req && !f_ack_q) || (d_req && !d_ack_q)) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign f_grant_cnt = f_grant_cnt_q;
    assign d_grant_cnt = d_grant_cnt_q;
    assign stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed steps plus randomized transactions
// checked against a transaction-level reference memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req, d_req, d_we;
    logic [63:0] f_addr, d_addr, d_wdata;
    logic [2:0]  d_sup;
    logic        f_ack, f_err, d_ack, d_err;
    logic [63:0] f_rdata, d_rdata;
    logic        mem_read, mem_write;
    logic [2:0]  mem_sup;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] f_grant_cnt, d_grant_cnt, stall_cnt;
`endif

    logic [63:0] bmem    [0:31];
    logic [63:0] ref_mem [0:31];
    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata), .f_err(f_err),
        .d_req(d_req), .d_we(d_we), .d_sup(d_sup), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_sup(mem_sup),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_CNT_EN
        , .f_grant_cnt(f_grant_cnt), .d_grant_cnt(d_grant_cnt), .stall_cnt(stall_cnt)
`endif
    );

    // Behavioural single-port memory with registered read.
    always @(posedge clk) begin
        if (mem_write) bmem[mem_addr[4:0]] <= mem_wdata;
        if (mem_read)  mem_rdata <= bmem[mem_addr[4:0]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction on a single port, checked against the reference memory.
    task automatic txn(input bit is_d, input bit we, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [2:0] sup);
        logic        err, got, ack;
        logic [63:0] exp_rd;
        int          lat, nrd, nwr;
        err    = (addr >= 64'd32);
        exp_rd = (err || we) ? 64'h0 : ref_mem[addr[4:0]];
        if (!err && we) ref_mem[addr[4:0]] = wdata;
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_sup = sup;
        end else begin
            f_req = 1'b1; f_addr = addr;
        end
        got = 1'b0; lat = 0; nrd = 0; nwr = 0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (mem_read) begin
                nrd++;
                chk("rd_addr", mem_addr, addr);
                chk("rd_sup", 64'(mem_sup), is_d ? 64'(sup) : 64'd3);
            end
            if (mem_write) begin
                nwr++;
                chk("wr_addr", mem_addr, addr);
                chk("wr_data", mem_wdata, wdata);
                chk("wr_sup", 64'(mem_sup), 64'(sup));
            end
            ack = is_d ? d_ack : f_ack;
            if (ack) begin
                got = 1'b1;
                lat = c;
                chk("rdata", is_d ? d_rdata : f_rdata, exp_rd);
                chk("err", 64'(is_d ? d_err : f_err), 64'(err));
                chk("other_ack", 64'(is_d ? f_ack : d_ack), 64'd0);
            end else if (c == 1) begin
                // Changes after the request is taken must be ignored.
                f_addr = {$urandom, $urandom}; d_addr = {$urandom, $urandom};
                d_wdata = {$urandom, $urandom}; d_we = ~d_we; d_sup = 3'($urandom);
            end else begin
                lat = 0;
            end
        end
        f_req = 1'b0; d_req = 1'b0;
        chk("ack_seen", 64'(got), 64'd1);
        chk("latency", 64'(lat), err ? 64'd1 : 64'd2);
        chk("n_read", 64'(nrd), 64'((!err && !we) ? 1 : 0));
        chk("n_write", 64'(nwr), 64'((!err && we) ? 1 : 0));
        @(negedge clk);
        chk("ack_pulse", 64'(f_ack | d_ack), 64'd0);
    endtask

    initial begin
        logic [63:0] v, a;
        bit          exp_f [0:7];
        bit          got_f [0:7];
        int          n, dcnt, seen;
        bit          is_d, we;
        for (int i = 0; i < 32; i++) begin
            v = {$urandom, $urandom};
            bmem[i] = v; ref_mem[i] = v;
        end
        bmem[5] = 64'hA5; ref_mem[5] = 64'hA5;
        rst_n = 1'b0; f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_sup = 3'b000;
        f_addr = 64'h0; d_addr = 64'h0; d_wdata = 64'h0;
        repeat (2) @(negedge clk);
        chk("rst_mem_read", 64'(mem_read), 64'd0);
        chk("rst_mem_write", 64'(mem_write), 64'd0);
        chk("rst_mem_sup", 64'(mem_sup), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'h0);
        chk("rst_mem_wdata", mem_wdata, 64'h0);
        chk("rst_acks", 64'({f_ack, d_ack, f_err, d_err}), 64'd0);
        chk("rst_f_rdata", f_rdata, 64'h0);
        chk("rst_d_rdata", d_rdata, 64'h0);
        rst_n = 1'b1;

`ifdef MEM_ARB_PERF_CNT_EN
        for (int i = 0; i < 4; i++) txn(1'b0, 1'b0, 64'(i), 64'h0, 3'b011);
        chk("perf_f_grant", 64'(f_grant_cnt), 64'd4);
        chk("perf_d_grant", 64'(d_grant_cnt), 64'd0);
        chk("perf_stall", 64'(stall_cnt), 64'd8);
`endif

        // Directed: fetch, store/load round trip, out-of-range accesses.
        txn(1'b0, 1'b0, 64'd5, 64'h0, 3'b011);
        txn(1'b1, 1'b1, 64'd7, 64'h1234, 3'b011);
        txn(1'b1, 1'b0, 64'd7, 64'h0, 3'b011);
        chk("load_back", ref_mem[7], 64'h1234);
        txn(1'b1, 1'b0, 64'd32, 64'h0, 3'b011);
        txn(1'b1, 1'b0, 64'h1_0000_0000, 64'h0, 3'b011);
        txn(1'b0, 1'b0, 64'd33, 64'h0, 3'b011);
        txn(1'b1, 1'b1, 64'd31, 64'hDEAD_BEEF_0000_0001, 3'b001);
        txn(1'b0, 1'b0, 64'd31, 64'h0, 3'b011);

        // Both requesters held: D wins at most three times in a row before F.
        @(negedge clk);
        f_req = 1'b1; f_addr = 64'd1; d_req = 1'b1; d_we = 1'b0; d_addr = 64'd2; d_sup = 3'b010;
        n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            @(negedge clk);
            if (f_ack || d_ack) begin
                chk("dual_ack", 64'(f_ack & d_ack), 64'd0);
                got_f[n] = f_ack;
                chk("cont_rdata", f_ack ? f_rdata : d_rdata, f_ack ? ref_mem[1] : ref_mem[2]);
                n++;
            end
        end
        f_req = 1'b0; d_req = 1'b0;
        chk("cont_count", 64'(n), 64'd8);
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            exp_f[i] = (dcnt == 3);
            dcnt = exp_f[i] ? 0 : dcnt + 1;
        end
        for (int i = 0; i < n; i++) chk("grant_order", 64'(got_f[i]), 64'(exp_f[i]));
        @(negedge clk);

        // Reset while a store is in its memory cycle.
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'd9; d_wdata = 64'h5555; d_sup = 3'b011;
        @(negedge clk);
        chk("pre_rst_write", 64'(mem_write), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_write_drop", 64'(mem_write), 64'd0);
        chk("rst_no_ack", 64'(d_ack), 64'd0);
        d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (d_ack || f_ack) seen++;
        end
        chk("post_rst_no_ack", 64'(seen), 64'd0);
        txn(1'b1, 1'b0, 64'd3, 64'h0, 3'b011);
        txn(1'b1, 1'b1, 64'd9, 64'h9999, 3'b011);

        // Randomized single-port traffic.
        for (int i = 0; i < 24; i++) begin
            is_d = 1'($urandom_range(0, 1));
            we   = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
            case ($urandom_range(0, 7))
                0:       a = 64'(32 + $urandom_range(0, 1000));
                1:       a = {32'($urandom | 32'd1), 32'($urandom_range(0, 31))};
                default: a = 64'($urandom_range(0, 31));
            endcase
            txn(is_d, we, a, {$urandom, $urandom}, 3'($urandom));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
